// File: rtl/uart_transmit_drain.sv
// uart_transmit_drain
//   Pulls bytes from a show-ahead transmit FIFO and sends them as UART frames:
//   start bit, DATAWIDTH data bits (LSB first), optional parity, 1 or 2 stops.
//   Each bit lasts max(baudDivisor,1) clocks. Frame configuration is sampled
//   once per frame at the pop, so input changes mid-frame only affect the
//   next frame.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   enable            gate for starting new frames (a running frame completes)
//   baudDivisor       clocks per bit (0 behaves as 1)
//   parityEn/Odd      parity enable / odd select
//   twoStop           two stop bits when high
//   fifoEmpty/Data    FIFO status and head word
//   fifoReadReq       one-cycle pop strobe
//   txd               serial line, idle high
//   busy              high from the pop through the end of the last stop bit
module uart_transmit_drain #(
  parameter int DATAWIDTH = 8,
  parameter int DIVWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIVWIDTH-1:0]  baudDivisor,
  input  logic                 parityEn,
  input  logic                 parityOdd,
  input  logic                 twoStop,
  input  logic                 fifoEmpty,
  input  logic [DATAWIDTH-1:0] fifoData,
  output logic                 fifoReadReq,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] shreg;
  logic [DIVWIDTH-1:0]  divm1;     // latched divisor-1 for this frame
  logic [DIVWIDTH-1:0]  bitTimer;
  logic [CW-1:0]        bitCount;  // data bit index, then stop bit index
  logic                 parEnR;
  logic                 twoStopR;
  logic                 parBit;    // seeded with parityOdd, XORs every data bit

  logic [DIVWIDTH-1:0]  divInM1;
  logic                 bitEnd;

  // divisor 0 behaves as 1, so no wrap below zero
  assign divInM1 = (baudDivisor == '0) ? '0 : baudDivisor - DIVWIDTH'(1);
  assign bitEnd  = (bitTimer == '0);

  // The pop is qualified by the live empty flag so a FIFO that drained
  // between IDLE and SETTLE is never popped.
  assign fifoReadReq = (state == SETTLE) && !fifoEmpty;
  assign busy        = fifoReadReq || (state inside {START, DATA, PARITY, STOP});

  // Line level decoded purely from flops; reset forces IDLE so the line
  // returns high immediately.
  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      PARITY:  txd = parBit;
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      divm1    <= '0;
      bitTimer <= '0;
      bitCount <= '0;
      parEnR   <= 1'b0;
      twoStopR <= 1'b0;
      parBit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !fifoEmpty) state <= SETTLE;
        end
        SETTLE: begin
          if (fifoEmpty) begin
            state <= IDLE;
          end else begin
            shreg    <= fifoData;
            divm1    <= divInM1;
            bitTimer <= divInM1;
            parEnR   <= parityEn;
            twoStopR <= twoStop;
            parBit   <= parityOdd;
            bitCount <= '0;
            state    <= START;
          end
        end
        START: begin
          if (!bitEnd) bitTimer <= bitTimer - DIVWIDTH'(1);
          else begin
            bitTimer <= divm1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!bitEnd) bitTimer <= bitTimer - DIVWIDTH'(1);
          else begin
            bitTimer <= divm1;
            parBit   <= parBit ^ shreg[0];
            shreg    <= shreg >> 1;
            if (bitCount == CW'(DATAWIDTH - 1)) begin
              bitCount <= '0;
              state    <= parEnR ? PARITY : STOP;
            end else begin
              bitCount <= bitCount + CW'(1);
            end
          end
        end
        PARITY: begin
          if (!bitEnd) bitTimer <= bitTimer - DIVWIDTH'(1);
          else begin
            bitTimer <= divm1;
            state    <= STOP;
          end
        end
        STOP: begin
          if (!bitEnd) bitTimer <= bitTimer - DIVWIDTH'(1);
          else if (twoStopR && bitCount == '0) begin
            bitCount <= CW'(1);
            bitTimer <= divm1;
          end else begin
            bitCount <= '0;
            // back-to-back frames go straight to SETTLE, keeping busy high
            state    <= (enable && !fifoEmpty) ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit_drain.sv
module tb_uart_transmit_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] baudDivisor = 16'd1;
  logic        parityEn = 1'b0, parityOdd = 1'b0, twoStop = 1'b0;
  logic        fifoEmpty = 1'b1;
  logic [7:0]  fifoData = 8'h00;
  logic        fifoReadReq, txd, busy;

  uart_transmit_drain #(.DATAWIDTH(8), .DIVWIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .baudDivisor(baudDivisor),
    .parityEn(parityEn), .parityOdd(parityOdd), .twoStop(twoStop),
    .fifoEmpty(fifoEmpty), .fifoData(fifoData),
    .fifoReadReq(fifoReadReq), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; int div; bit pe, po, ts;} frame_t;

  int errors = 0, checks = 0, viol = 0;
  logic [7:0] fq[$];          // FIFO model
  frame_t     fr[$];          // frames expected on the line
  logic [2:0] tr[$], ex[$];   // per-cycle {txd,busy,fifoReadReq}: observed / expected
  logic s_txd, s_busy, s_rreq, s_empty;

  task automatic upd();
    fifoEmpty = (fq.size() == 0);
    fifoData  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    upd();
  endtask

  // sample mid-cycle, then apply the FIFO pop just after the clock edge
  task automatic step();
    @(negedge clk);
    s_txd = txd; s_busy = busy; s_rreq = fifoReadReq; s_empty = fifoEmpty;
    @(posedge clk);
    #1;
    if (s_rreq && fq.size() != 0) void'(fq.pop_front());
    upd();
  endtask

  // record the line until busy has been seen and has fallen again
  task automatic capture(input int chg, input logic [15:0] nd, input bit np,
                         input bit ne, output bit to);
    bit seen = 0;
    tr.delete();
    to = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c == chg) begin baudDivisor = nd; parityEn = np; enable = ne; end
      step();
      tr.push_back({s_txd, s_busy, s_rreq});
      if (s_rreq && s_empty) viol++;
      if (s_busy) seen = 1;
      else if (seen) begin to = 0; return; end
    end
  endtask

  // reference: one idle cycle, then per frame a pop cycle and the bit list
  // with every bit held max(div,1) clocks, then one idle cycle
  function automatic void build_exp();
    ex.delete();
    ex.push_back(3'b100);
    foreach (fr[i]) begin
      int dd;
      bit b[$];
      dd = (fr[i].div == 0) ? 1 : fr[i].div;
      b.push_back(1'b0);
      for (int k = 0; k < 8; k++) b.push_back(fr[i].d[k]);
      if (fr[i].pe) b.push_back((^fr[i].d) ^ fr[i].po);
      b.push_back(1'b1);
      if (fr[i].ts) b.push_back(1'b1);
      ex.push_back(3'b111);
      foreach (b[k]) for (int r = 0; r < dd; r++) ex.push_back({b[k], 2'b10});
    end
    ex.push_back(3'b100);
  endfunction

  function automatic int first_diff();
    int n = (tr.size() > ex.size()) ? tr.size() : ex.size();
    for (int i = 0; i < n; i++)
      if (i >= tr.size() || i >= ex.size() || tr[i] !== ex[i]) return i;
    return -1;
  endfunction

  function automatic frame_t mk(input logic [7:0] d, input int div,
                                input bit pe, input bit po, input bit ts);
    frame_t f;
    f.d = d; f.div = div; f.pe = pe; f.po = po; f.ts = ts;
    return f;
  endfunction

  task automatic cfg(input int div, input bit pe, input bit po, input bit ts);
    baudDivisor = 16'(div); parityEn = pe; parityOdd = po; twoStop = ts;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #12;
    checks++;
    if ({txd, busy, fifoReadReq} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: got txd/busy/rreq=%b want 100", {txd, busy, fifoReadReq});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to; int d, pops;
    cfg(4, 0, 0, 0);
    push(8'h55);
    fr.delete(); fr.push_back(mk(8'h55, 4, 0, 0, 0));
    build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL basic_trace: to=%0d cycle %0d got %b want %b len %0d want %0d",
               to, d, (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx,
               (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx, tr.size(), ex.size());
    end
    pops = 0;
    foreach (tr[i]) if (tr[i][0]) pops++;
    checks++;
    if (pops != 1 || tr.size() != 43) begin
      errors++;
      $display("FAIL basic_pops_len: got pops=%0d len=%0d want 1 and 43", pops, tr.size());
    end
  endtask

  task automatic test_parity();
    bit to; int d;
    cfg(1, 1, 0, 1);
    push(8'h07);
    fr.delete(); fr.push_back(mk(8'h07, 1, 1, 0, 1));
    build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
    checks++;
    if (to || d != -1 || tr.size() != 15) begin
      errors++;
      $display("FAIL parity_trace: to=%0d cycle %0d got %b want %b len %0d want %0d",
               to, d, (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx,
               (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx, tr.size(), ex.size());
    end
  endtask

  task automatic test_back_to_back();
    bit to; int d;
    logic [7:0] bytes [3];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    cfg(2, 0, 0, 0);
    fr.delete();
    foreach (bytes[i]) begin push(bytes[i]); fr.push_back(mk(bytes[i], 2, 0, 0, 0)); end
    build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL b2b_trace: to=%0d cycle %0d got %b want %b len %0d want %0d",
               to, d, (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx,
               (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx, tr.size(), ex.size());
    end
  endtask

  task automatic test_random();
    bit to; int d, n, div; bit pe, po, ts;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3); div = $urandom_range(0, 3);
      pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
      cfg(div, pe, po, ts);
      fr.delete();
      for (int j = 0; j < n; j++) begin
        logic [7:0] b = 8'($urandom);
        push(b); fr.push_back(mk(b, div, pe, po, ts));
      end
      build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
      checks++;
      if (to || d != -1) begin
        errors++;
        $display("FAIL random_trace[%0d]: to=%0d cycle %0d got %b want %b len %0d want %0d",
                 it, to, d, (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx,
                 (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx, tr.size(), ex.size());
      end
    end
  endtask

  task automatic test_midframe_change();
    bit to; int d;
    cfg(4, 0, 0, 0);
    push(8'hC3); push(8'h81);
    fr.delete();
    fr.push_back(mk(8'hC3, 4, 0, 0, 0));
    fr.push_back(mk(8'h81, 8, 1, 0, 0));
    build_exp(); capture(10, 16'd8, 1, 1, to); d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL midframe_trace: to=%0d cycle %0d got %b want %b len %0d want %0d",
               to, d, (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx,
               (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx, tr.size(), ex.size());
    end
  endtask

  task automatic test_enable();
    bit to; int d, bad;
    cfg(2, 0, 0, 0);
    enable = 1'b0;
    push(8'h3C);
    bad = 0;
    repeat (20) begin step(); if (s_rreq || s_busy || !s_txd) bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL disabled_idle: got %0d active cycles want 0", bad);
    end
    enable = 1'b1;
    fr.delete(); fr.push_back(mk(8'h3C, 2, 0, 0, 0));
    build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL enable_trace: to=%0d cycle %0d got %b want %b", to, d,
               (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx, (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx);
    end
    // drop enable mid-frame with two words queued: exactly one frame goes out
    push(8'h96); push(8'h69);
    fr.delete(); fr.push_back(mk(8'h96, 2, 0, 0, 0));
    build_exp(); capture(6, 16'd2, 0, 0, to); d = first_diff();
    checks++;
    if (to || d != -1 || fq.size() != 1) begin
      errors++;
      $display("FAIL enable_drop: to=%0d cycle %0d got %b want %b fifo left %0d want 1", to, d,
               (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx, (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx,
               fq.size());
    end
    enable = 1'b1;
    fr.delete(); fr.push_back(mk(8'h69, 2, 0, 0, 0));
    build_exp(); capture(-1, 0, 0, 1, to); d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL enable_resume: to=%0d cycle %0d got %b want %b", to, d,
               (d >= 0 && d < tr.size()) ? tr[d] : 3'bxxx, (d >= 0 && d < ex.size()) ? ex[d] : 3'bxxx);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    cfg(4, 0, 0, 0);
    push(8'h52);   // bit 3 is 0, so the line is low when reset hits
    repeat (20) step();
    #2;
    checks++;
    if ({txd, busy} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_bit3: got txd/busy=%b want 01", {txd, busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({txd, busy, fifoReadReq} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset: got txd/busy/rreq=%b want 100", {txd, busy, fifoReadReq});
    end
    #10 reset = 1'b0;
    bad = 0;
    repeat (10) begin step(); if (s_rreq || s_busy || !s_txd) bad++; end
    checks++;
    if (bad != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d active cycles fifo %0d want 0 0", bad, fq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_random();
    test_midframe_change();
    test_enable();
    test_reset_mid();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL pop_when_empty: got %0d cycles want 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
